// File: rtl/seg_pkg.sv
// Shared types and segment constants for the six-digit seven-segment scan driver.
// Patterns are logical active-high, bit order g..a.
package seg_pkg;

   localparam int NUM_DIGITS = 6;

   typedef logic [2:0] idx_t;
   typedef logic [6:0] seg_t;

   typedef enum logic {
      PH_BLANK = 1'b0,
      PH_DRIVE = 1'b1
   } phase_t;

   localparam seg_t SEG_0    = 7'h3F;
   localparam seg_t SEG_1    = 7'h06;
   localparam seg_t SEG_2    = 7'h5B;
   localparam seg_t SEG_3    = 7'h4F;
   localparam seg_t SEG_4    = 7'h66;
   localparam seg_t SEG_5    = 7'h6D;
   localparam seg_t SEG_6    = 7'h7D;
   localparam seg_t SEG_7    = 7'h07;
   localparam seg_t SEG_8    = 7'h7F;
   localparam seg_t SEG_9    = 7'h6F;
   localparam seg_t SEG_DASH = 7'h40;

   // Logical (active-high) digit enable for a scan index.
   function automatic logic [NUM_DIGITS-1:0] dig_onehot(input idx_t idx);
      logic [NUM_DIGITS-1:0] one_s;
      one_s = 6'b000001;
      return one_s << idx;
   endfunction

endpackage

// File: rtl/seg_scan_driver_if.sv
// Time bus in from the clock core plus the display pin bundle out of the scan driver.
// master drives time/enable/tick; slave is the scan driver.
interface seg_scan_driver_if;

   logic       EN;
   logic       CP_1Hz;
   logic [7:0] Hour;
   logic [7:0] Minute;
   logic [7:0] Second;
   logic [5:0] dig;
   logic [7:0] smg;

   modport master (
      output EN,
      output CP_1Hz,
      output Hour,
      output Minute,
      output Second,
      input  dig,
      input  smg
   );

   modport slave (
      input  EN,
      input  CP_1Hz,
      input  Hour,
      input  Minute,
      input  Second,
      output dig,
      output smg
   );

endinterface

// File: rtl/seg_decode.sv
// Combinational BCD nibble to seven-segment pattern (g..a, active-high).
// Nibbles A-F render as a dash so corrupt time values are visible rather than garbage.
module seg_decode
   import seg_pkg::*;
(
   input  logic [3:0] nibble,
   output seg_t       pattern
);

   // Nibble lookup with dash fallback
   always_comb begin
      pattern = SEG_DASH;
      case (nibble)
         4'd0:    pattern = SEG_0;
         4'd1:    pattern = SEG_1;
         4'd2:    pattern = SEG_2;
         4'd3:    pattern = SEG_3;
         4'd4:    pattern = SEG_4;
         4'd5:    pattern = SEG_5;
         4'd6:    pattern = SEG_6;
         4'd7:    pattern = SEG_7;
         4'd8:    pattern = SEG_8;
         4'd9:    pattern = SEG_9;
         default: pattern = SEG_DASH;
      endcase
   end

endmodule

// File: rtl/seg_scan_driver.sv
// Six-digit multiplexed seven-segment driver with per-slot dead-time and a per-frame time snapshot.
// Optional decimal-point blink on idx2/idx4 is built only when SEG_DP_BLINK_EN is defined.
module seg_scan_driver
   import seg_pkg::*;
#(
   parameter int SCAN_DIV       = 12000,
   parameter int BLANK_CYC      = 120,
   parameter int SEG_ACTIVE_LOW = 1,
   parameter int DIG_ACTIVE_LOW = 1
) (
   input  logic              CLK_12,
   input  logic              CR,
   seg_scan_driver_if.slave  bus
);

   localparam int                     CNT_W     = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 2;
   localparam logic [CNT_W-1:0]       CNT_LAST  = CNT_W'(SCAN_DIV - 1);
   localparam logic [CNT_W-1:0]       BLANK_END = CNT_W'(BLANK_CYC);
   localparam idx_t                   IDX_LAST  = idx_t'(NUM_DIGITS - 1);
   localparam logic [7:0]             SMG_MASK  = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
   localparam logic [NUM_DIGITS-1:0]  DIG_MASK  = (DIG_ACTIVE_LOW != 0) ? 6'h3F : 6'h00;
   localparam logic [7:0]             SMG_OFF   = 8'h00 ^ SMG_MASK;
   localparam logic [NUM_DIGITS-1:0]  DIG_OFF   = 6'h00 ^ DIG_MASK;

   logic [CNT_W-1:0]      cnt_r;
   idx_t                  idx_r;
   logic [23:0]           snap_r;
   logic [NUM_DIGITS-1:0] dig_r;
   logic [7:0]            smg_r;

   phase_t                phase_s;
   logic [3:0]            nibble_s;
   seg_t                  pattern_s;
   logic                  dp_s;

   // Slot phase: dead-time at the start of every slot, drive for the rest
   always_comb begin
      phase_s = PH_BLANK;
      if (cnt_r < BLANK_END) begin
         phase_s = PH_BLANK;
      end else begin
         phase_s = PH_DRIVE;
      end
   end

   // Select the snapshot nibble for the current digit (snapshot = {Hour, Minute, Second})
   always_comb begin
      nibble_s = 4'd0;
      case (idx_r)
         3'd0:    nibble_s = snap_r[3:0];
         3'd1:    nibble_s = snap_r[7:4];
         3'd2:    nibble_s = snap_r[11:8];
         3'd3:    nibble_s = snap_r[15:12];
         3'd4:    nibble_s = snap_r[19:16];
         3'd5:    nibble_s = snap_r[23:20];
         default: nibble_s = 4'd0;
      endcase
   end

   seg_decode u_decode (
      .nibble  (nibble_s),
      .pattern (pattern_s)
   );

`ifdef SEG_DP_BLINK_EN
   logic cp_d_r;
   logic blink_r;

   // 1 Hz rising-edge detector toggling the decimal-point phase
   always_ff @(posedge CLK_12) begin
      if (CR) begin
         cp_d_r  <= 1'b0;
         blink_r <= 1'b0;
      end else begin
         cp_d_r <= bus.CP_1Hz;
         if (bus.CP_1Hz && !cp_d_r) begin
            blink_r <= ~blink_r;
         end else begin
            blink_r <= blink_r;
         end
      end
   end

   // Decimal point sits between hours/minutes and minutes/seconds
   always_comb begin
      dp_s = 1'b0;
      if (blink_r && ((idx_r == 3'd2) || (idx_r == 3'd4))) begin
         dp_s = 1'b1;
      end else begin
         dp_s = 1'b0;
      end
   end
`else
   logic unused_cp_s;

   assign unused_cp_s = bus.CP_1Hz;
   assign dp_s        = 1'b0;
`endif

   // Prescaler, digit index, frame snapshot and pin registers (polarity applied here, last)
   always_ff @(posedge CLK_12) begin
      if (CR) begin
         cnt_r  <= {CNT_W{1'b0}};
         idx_r  <= 3'd0;
         snap_r <= 24'h000000;
         dig_r  <= DIG_OFF;
         smg_r  <= SMG_OFF;
      end else if (!bus.EN) begin
         cnt_r  <= cnt_r;
         idx_r  <= idx_r;
         snap_r <= snap_r;
         dig_r  <= DIG_OFF;
         smg_r  <= SMG_OFF;
      end else begin
         if (cnt_r == CNT_LAST) begin
            cnt_r <= {CNT_W{1'b0}};
            if (idx_r == IDX_LAST) begin
               // Frame boundary: one coherent copy of the time for all six digits
               idx_r  <= 3'd0;
               snap_r <= {bus.Hour, bus.Minute, bus.Second};
            end else begin
               idx_r  <= idx_r + 3'd1;
               snap_r <= snap_r;
            end
         end else begin
            cnt_r  <= cnt_r + CNT_W'(1);
            idx_r  <= idx_r;
            snap_r <= snap_r;
         end

         if (phase_s == PH_DRIVE) begin
            dig_r <= dig_onehot(idx_r) ^ DIG_MASK;
            smg_r <= {dp_s, pattern_s} ^ SMG_MASK;
         end else begin
            dig_r <= DIG_OFF;
            smg_r <= SMG_OFF;
         end
      end
   end

   assign bus.dig = dig_r;
   assign bus.smg = smg_r;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed plus randomized bench for seg_scan_driver; every cycle is checked against a
// model that derives slot/digit/frame from an enabled-cycle count with plain arithmetic.
module tb_seg_scan_driver;

   localparam int SD = 20;
   localparam int BC = 4;
   localparam int FRAME = 6 * SD;

   logic clk = 1'b0;
   logic cr;

   always #5 clk = ~clk;

   seg_scan_driver_if bus_if ();

   seg_scan_driver #(
      .SCAN_DIV       (SD),
      .BLANK_CYC      (BC),
      .SEG_ACTIVE_LOW (0),
      .DIG_ACTIVE_LOW (0)
   ) dut (
      .CLK_12 (clk),
      .CR     (cr),
      .bus    (bus_if)
   );

   int          n_cmp = 0;
   int          n_bad = 0;

   // Model: m_n counts enabled cycles since reset; slot, digit and frame follow from it.
   int          m_n = 0;
   logic [23:0] m_snap = 24'h0;
   bit          m_blink = 1'b0;
   bit          m_cp_prev = 1'b0;
   logic [6:0]  pat [16];
   logic [5:0]  exp_dig;
   logic [7:0]  exp_smg;

   function automatic int m_pos();
      return m_n % SD;
   endfunction

   function automatic int m_idx();
      return (m_n / SD) % 6;
   endfunction

   task automatic step(input string tag);
      int         pos;
      int         idx;
      logic [3:0] nib;
      pos     = m_pos();
      idx     = m_idx();
      exp_dig = 6'h00;
      exp_smg = 8'h00;
      if (!cr && bus_if.EN && pos >= BC) begin
         nib     = m_snap[idx*4 +: 4];
         exp_dig = 6'(1 << idx);
         exp_smg = {1'b0, pat[nib]};
`ifdef SEG_DP_BLINK_EN
         exp_smg[7] = m_blink && (idx == 2 || idx == 4);
`endif
      end
      if (cr) begin
         m_n       = 0;
         m_snap    = 24'h0;
         m_blink   = 1'b0;
         m_cp_prev = 1'b0;
      end else begin
         if (bus_if.CP_1Hz && !m_cp_prev) m_blink = !m_blink;
         m_cp_prev = bus_if.CP_1Hz;
         if (bus_if.EN) begin
            if (pos == SD - 1 && idx == 5) m_snap = {bus_if.Hour, bus_if.Minute, bus_if.Second};
            m_n++;
         end
      end
      @(posedge clk);
      #1;
      n_cmp++;
      assert (bus_if.dig === exp_dig) else begin
         n_bad++;
         $error("FAIL %s dig: got %b expected %b (t=%0t)", tag, bus_if.dig, exp_dig, $time);
      end
      n_cmp++;
      assert (bus_if.smg === exp_smg) else begin
         n_bad++;
         $error("FAIL %s smg: got %h expected %h (t=%0t)", tag, bus_if.smg, exp_smg, $time);
      end
   endtask

   task automatic run(input int cycles, input string tag);
      for (int i = 0; i < cycles; i++) step(tag);
   endtask

   // Advance until the model reaches a given digit/position (bounded by two frames).
   task automatic run_to(input int idx, input int pos, input string tag);
      int guard;
      guard = 0;
      while (!(m_idx() == idx && m_pos() == pos) && guard < 2 * FRAME) begin
         step(tag);
         guard++;
      end
      n_cmp++;
      assert (guard < 2 * FRAME) else begin
         n_bad++;
         $error("FAIL %s run_to: got timeout expected idx %0d pos %0d", tag, idx, pos);
      end
   endtask

   task automatic cp_pulse(input string tag);
      bus_if.CP_1Hz = 1'b1;
      step(tag);
      bus_if.CP_1Hz = 1'b0;
   endtask

   function automatic logic [7:0] rand_bcd(input int tens_max);
      return {4'($urandom_range(0, tens_max)), 4'($urandom_range(0, 9))};
   endfunction

   initial begin
      pat[0]  = 7'h3F; pat[1]  = 7'h06; pat[2]  = 7'h5B; pat[3]  = 7'h4F;
      pat[4]  = 7'h66; pat[5]  = 7'h6D; pat[6]  = 7'h7D; pat[7]  = 7'h07;
      pat[8]  = 7'h7F; pat[9]  = 7'h6F;
      for (int k = 10; k < 16; k++) pat[k] = 7'h40;

      cr            = 1'b1;
      bus_if.EN     = 1'b0;
      bus_if.CP_1Hz = 1'b0;
      bus_if.Hour   = 8'h00;
      bus_if.Minute = 8'h00;
      bus_if.Second = 8'h00;

      run(2, "reset");
      bus_if.EN = 1'b1;
      run(1, "reset");
      cr = 1'b0;
      run(SD + 1, "first_digit");

      bus_if.Hour   = 8'h23;
      bus_if.Minute = 8'h59;
      bus_if.Second = 8'h58;
      run(2 * FRAME, "full_frame");

      run_to(3, 8, "tear_seek");
      bus_if.Second = 8'h59;
      run(FRAME + FRAME / 2, "tear_free");

      bus_if.Minute = 8'h7C;
      run(2 * FRAME, "bad_bcd");
      bus_if.Minute = 8'h59;

      run_to(3, 10, "en_seek");
      bus_if.EN = 1'b0;
      run(50, "en_low");
      bus_if.EN = 1'b1;
      run(SD + 5, "en_resume");

      cr        = 1'b1;
      bus_if.EN = 1'b0;
      run(2, "cr_priority");
      cr        = 1'b0;
      bus_if.EN = 1'b1;
      run(SD + 6, "after_cr");

      cp_pulse("blink_on");
      run(FRAME + 10, "blink_on");
      cp_pulse("blink_off");
      run(FRAME + 10, "blink_off");

      for (int r = 0; r < 40; r++) begin
         bus_if.Hour   = ($urandom_range(0, 7) == 0) ? 8'($urandom) : rand_bcd(2);
         bus_if.Minute = ($urandom_range(0, 7) == 0) ? 8'($urandom) : rand_bcd(5);
         bus_if.Second = rand_bcd(5);
         bus_if.EN     = ($urandom_range(0, 5) != 0);
         bus_if.CP_1Hz = ($urandom_range(0, 3) == 0);
         cr            = ($urandom_range(0, 19) == 0);
         run(int'($urandom_range(1, 60)), "random");
      end
      cr            = 1'b0;
      bus_if.EN     = 1'b1;
      bus_if.CP_1Hz = 1'b0;
      run(FRAME, "random_tail");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/seg_scan_driver.md
# seg_scan_driver

Display-side consumer of the BCD time bus produced by the clock core (`Hour`, `Minute`, `Second`, packed BCD). It multiplexes a six-digit seven-segment display, one digit per scan slot. It inserts a dead-time blank at the start of every slot to suppress ghosting. It latches a tear-free snapshot of the time once per frame and drives registered segment and digit-select outputs straight to the pins.

## Interface
- `SCAN_DIV`, 12000: clock cycles per digit slot (1 kHz slot rate at 12 MHz); minimum 4.
- `BLANK_CYC`, 120: dead-time cycles at the start of each slot; must be in 1..SCAN_DIV-2.
- `SEG_ACTIVE_LOW`, 1: 1 inverts `smg` at the pin (common-anode display).
- `DIG_ACTIVE_LOW`, 1: 1 inverts `dig` at the pin.
- `CLK_12`  in  1  system clock.
- `CR`  in  1  reset; synchronous, active-high.
- `EN`  in  1  scan enable; low freezes scanning and blanks the display.
- `CP_1Hz`  in  1  1 Hz tick, synchronous to `CLK_12`; used only with the `SEG_DP_BLINK_EN` macro.
- `Hour`  in  8  BCD hours, [7:4] tens, [3:0] units.
- `Minute`  in  8  BCD minutes.
- `Second`  in  8  BCD seconds.
- `dig`  out  6  digit enables, one-hot when active. Bit 0 is second units and bit 5 is hour tens.
- `smg`  out  8  segments: [7] dp, [6:0] g..a.

## Operation
- **Prescaler** `cnt`: counts 0..SCAN_DIV-1 and wraps to 0. The digit index `idx` (0..5) advances on each wrap, and 5 wraps to 0.
- **Phase, derived from `cnt`:**
  - BLANK when `cnt < BLANK_CYC`.
  - DRIVE otherwise.
- **Snapshot:** the cycle where `cnt` wraps and `idx` goes 5→0 loads `Hour`, `Minute` and `Second` into a 24-bit snapshot. All six digits of a frame come from one snapshot.
- **Digit map:** idx0 `Second[3:0]`, idx1 `Second[7:4]`, idx2 `Minute[3:0]`, idx3 `Minute[7:4]`, idx4 `Hour[3:0]`, idx5 `Hour[7:4]`.
- **Decode, logical active-high g..a:**
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - Any nibble A–F decodes to a dash, 40.
- **Outputs in BLANK:** `dig` all inactive and `smg` all off.
- **Outputs in DRIVE:** `dig` is one-hot on `idx` and `smg` is the decoded pattern.
- **Polarity:** applied last, at the output register.
- **`EN` low:**
  - `cnt`, `idx` and the snapshot hold their values.
  - Outputs go blank on the next edge.
  - When `EN` returns high, counting resumes from the held `cnt` and `idx`.
- **`CR`:** has priority over `EN`.

## Timing
- **Reset values:** `cnt`=0, `idx`=0, snapshot=0, blink phase=0, `dig` inactive, `smg` off (pin level honours the polarity parameters).
- **Output latency:** outputs are registered and lag the `cnt`/`idx` state by one cycle.
  - `dig` becomes active on the edge after the cycle with `cnt`==BLANK_CYC.
  - `dig` goes inactive on the edge after the cycle with `cnt`==0 (slot start).
- **DRIVE width:** exactly SCAN_DIV-BLANK_CYC cycles per slot.
- **Frame period:** 6·SCAN_DIV cycles.
- **Snapshot latency:** a change on the time inputs is first displayed in the frame after the next snapshot load. Worst case is 2 frames.
- **Mid-frame input changes:** an input change in the same cycle as the snapshot load is captured. A change mid-frame never mixes into the current frame.
- **Reset mid-slot:** `CR` mid-slot blanks the outputs on the next edge. The first DRIVE after release is idx0, BLANK_CYC+1 edges later.

## Configuration
- **`SEG_DP_BLINK_EN` defined:**
  - A rising-edge detector on `CP_1Hz` toggles the blink phase on each rising edge.
  - `smg[7]` is lit during DRIVE of idx2 and idx4 while the phase is 1.
  - The phase is registered and updates immediately, not per frame.
- **`SEG_DP_BLINK_EN` undefined:** `smg[7]` is always off; `CP_1Hz` is unused and no blink logic is built.

## Structure
- **Package `seg_pkg`:**
  - the ten digit patterns and the dash pattern as 7-bit constants;
  - `NUM_DIGITS`=6;
  - the digit-index typedef (3 bits).
- **Sub-module `seg_decode`:** combinational, maps a 4-bit nibble to the 7-bit pattern including the dash. It is instantiated once, fed by the nibble mux on `idx`.

## Test plan
Bench parameters: `SCAN_DIV`=20, `BLANK_CYC`=4, both polarity parameters 0.
- **Reset and first digit:** assert `CR` 3 cycles, release with `EN`=1.
  - `dig`=0 and `smg`=0 for 5 edges.
  - Then `dig`=000001 and `smg`=3F (snapshot zero) for 16 cycles.
- **Full frame:** time inputs 23:59:58, run 2 frames. Second frame shows:
  - idx0 7F, idx1 6D, idx2 6F, idx3 6D, idx4 4F, idx5 5B;
  - `dig` one-hot in order 1,2,4,8,16,32.
- **Tear-free update:** change `Second` from 58 to 59 in mid-frame during idx3.
  - The remaining digits of that frame are unchanged.
  - The next frame shows idx0 6F only after a snapshot load.
- **Invalid BCD:** `Minute`=8'h7C.
  - idx2 shows 40 (dash).
  - idx3 shows 07.
- **Enable and reset priority:**
  - Drop `EN` during DRIVE of idx3: blank on the next edge; after 50 cycles re-raise `EN`; idx3 resumes with the remaining slot count.
  - Assert `CR` and `EN`=0 together: state returns to reset values.
- **`SEG_DP_BLINK_EN` build:** pulse `CP_1Hz` once.
  - idx2 and idx4 show `smg[7]`=1 and all other digits 0.
  - A second pulse clears it.
  - Non-macro build: `smg[7]` is always 0.
